// File: rtl/aurora_init_pkg.sv
// Shared types and default timing for the Aurora init sequencer.
// Optional retry/timeout logic is compiled in with AURORA_INIT_RETRY_EN.
package aurora_init_pkg;

  typedef enum logic [1:0] {
    SEQ     = 2'd0,
    WAIT_UP = 2'd1,
    LINKED  = 2'd2
  } init_state_t;

  localparam int DEF_AURORA_RST_CYC = 100;
  localparam int DEF_GT_LOW_START   = 490;
  localparam int DEF_GT_PULSE_CYC   = 10;
  localparam int DEF_STABLE_CYC     = 8;
  localparam int DEF_LINK_TIMEOUT   = 4096;
  localparam int DEF_CNT_W          = 16;
  localparam int RETRY_W            = 8;

  // Width needed to count 0..stable_cyc inclusive (never below 1 bit).
  function automatic int stab_width(input int stable_cyc);
    return (stable_cyc < 1) ? 1 : $clog2(stable_cyc + 1);
  endfunction

endpackage

// File: rtl/aurora_init_ctrl_debounce.sv
// Per-channel channel_up debouncer: input register, saturating stability
// counter and registered active-high reset for the TX/RX blocks.
// Module name: aurora_chup_debounce.
module aurora_chup_debounce
  import aurora_init_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic init_clk,
  input  logic RST,
  input  logic enable,
  input  logic channel_up,
  output logic reset_TX_RX_Block
);

  localparam int                STAB_W   = stab_width(STABLE_CYC);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);

  logic              chup_reg;
  logic [STAB_W-1:0] stab_reg;

  // Register the raw channel_up once before it is used anywhere.
  always_ff @(posedge init_clk) begin
    if (RST) chup_reg <= 1'b0;
    else     chup_reg <= channel_up;
  end

  // Count consecutive high samples; release only once the count saturates.
  always_ff @(posedge init_clk) begin
    if (RST || !enable) begin
      stab_reg          <= '0;
      reset_TX_RX_Block <= 1'b1;
    end else begin
      reset_TX_RX_Block <= (stab_reg != STAB_MAX);
      if (!chup_reg)
        stab_reg <= '0;
      else if (stab_reg != STAB_MAX)
        stab_reg <= stab_reg + 1'b1;
    end
  end

endmodule

// File: rtl/aurora_init_ctrl.sv
// Power-up / re-init sequencer for one Aurora core with N_CH channels.
// Define AURORA_INIT_RETRY_EN to add link timeout and loss-of-link restart.
module aurora_init_ctrl
  import aurora_init_pkg::*;
#(
  parameter int N_CH           = 1,
  parameter int AURORA_RST_CYC = DEF_AURORA_RST_CYC,
  parameter int GT_LOW_START   = DEF_GT_LOW_START,
  parameter int GT_PULSE_CYC   = DEF_GT_PULSE_CYC,
  parameter int STABLE_CYC     = DEF_STABLE_CYC,
  parameter int LINK_TIMEOUT   = DEF_LINK_TIMEOUT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic               init_clk,
  input  logic               RST,
  input  logic [N_CH-1:0]    channel_up,
  output logic               reset_Aurora,
  output logic               gt_reset,
  output logic [N_CH-1:0]    reset_TX_RX_Block,
  output logic               all_up,
  output logic               init_done,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] AURORA_REL   = CNT_W'(AURORA_RST_CYC);
  localparam logic [CNT_W-1:0] GT_LOW_BEG   = CNT_W'(GT_LOW_START);
  localparam logic [CNT_W-1:0] GT_HIGH_BEG  = CNT_W'(GT_LOW_START + GT_PULSE_CYC);
  localparam logic [CNT_W-1:0] GT_SEQ_END   = CNT_W'(GT_LOW_START + 2 * GT_PULSE_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT - 1);

  init_state_t      state_reg;
  logic [CNT_W-1:0] seq_cnt_reg;
  logic             all_deb;
  logic             restart;
  logic             deb_en;

  // A channel is debounced once its reset output has dropped.
  assign all_deb = ~|reset_TX_RX_Block;

`ifdef AURORA_INIT_RETRY_EN
  // Timeout and drop are mutually exclusive by state, so one retry per event.
  assign restart = ((state_reg == WAIT_UP) && !all_deb && (seq_cnt_reg == TIMEOUT_LAST)) ||
                   ((state_reg == LINKED)  && !all_deb);
`else
  assign restart = 1'b0;
`endif

  // Debouncers run only after the core sequence and are cleared by a restart.
  assign deb_en = (state_reg != SEQ) && !restart;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_deb
      aurora_chup_debounce #(
        .STABLE_CYC(STABLE_CYC)
      ) u_deb (
        .init_clk         (init_clk),
        .RST              (RST),
        .enable           (deb_en),
        .channel_up       (channel_up[gi]),
        .reset_TX_RX_Block(reset_TX_RX_Block[gi])
      );
    end
  endgenerate

  // Sequencer FSM with registered reset_Aurora / gt_reset / init_done.
  always_ff @(posedge init_clk) begin
    if (RST || restart) begin
      state_reg    <= SEQ;
      seq_cnt_reg  <= '0;
      reset_Aurora <= 1'b1;
      gt_reset     <= 1'b1;
      init_done    <= 1'b0;
    end else begin
      case (state_reg)
        SEQ: begin
          reset_Aurora <= (seq_cnt_reg < AURORA_REL);
          gt_reset     <= (seq_cnt_reg < GT_LOW_BEG) ||
                          ((seq_cnt_reg >= GT_HIGH_BEG) && (seq_cnt_reg < GT_SEQ_END));
          if (seq_cnt_reg == GT_SEQ_END) begin
            state_reg   <= WAIT_UP;
            seq_cnt_reg <= '0;
            init_done   <= 1'b1;
          end else begin
            seq_cnt_reg <= seq_cnt_reg + 1'b1;
            init_done   <= 1'b0;
          end
        end
        WAIT_UP: begin
          reset_Aurora <= 1'b0;
          gt_reset     <= 1'b0;
          init_done    <= 1'b1;
          if (all_deb)
            state_reg <= LINKED;
          else if (seq_cnt_reg != TIMEOUT_LAST)
            seq_cnt_reg <= seq_cnt_reg + 1'b1;
        end
        LINKED: begin
          reset_Aurora <= 1'b0;
          gt_reset     <= 1'b0;
          init_done    <= 1'b1;
          if (!all_deb) begin
            state_reg   <= WAIT_UP;
            seq_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg    <= SEQ;
          seq_cnt_reg  <= '0;
          reset_Aurora <= 1'b1;
          gt_reset     <= 1'b1;
          init_done    <= 1'b0;
        end
      endcase
    end
  end

  // all_up follows the debounced channel resets by one cycle.
  always_ff @(posedge init_clk) begin
    if (RST) all_up <= 1'b0;
    else     all_up <= all_deb;
  end

`ifdef AURORA_INIT_RETRY_EN
  // Saturating count of sequence restarts.
  always_ff @(posedge init_clk) begin
    if (RST)
      retry_cnt <= '0;
    else if (restart && (retry_cnt != {RETRY_W{1'b1}}))
      retry_cnt <= retry_cnt + 1'b1;
  end
`else
  assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_init_ctrl.sv
// Randomised bench for aurora_init_ctrl (N_CH=4, LINK_TIMEOUT=64) against a
// timeline / sliding-window model of the init sequence.
module tb_aurora_init_ctrl;

  localparam int NC   = 4;
  localparam int AUR  = 100;
  localparam int GTL  = 490;
  localparam int GTP  = 10;
  localparam int STB  = 8;
  localparam int LTO  = 64;
  localparam int MAXE = 16384;
`ifdef AURORA_INIT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          init_clk = 1'b0;
  logic          RST;
  logic [NC-1:0] channel_up;
  logic          reset_Aurora, gt_reset, all_up, init_done;
  logic [NC-1:0] reset_TX_RX_Block;
  logic [7:0]    retry_cnt;

  aurora_init_ctrl #(
    .N_CH(NC), .AURORA_RST_CYC(AUR), .GT_LOW_START(GTL), .GT_PULSE_CYC(GTP),
    .STABLE_CYC(STB), .LINK_TIMEOUT(LTO), .CNT_W(16)
  ) dut (
    .init_clk(init_clk), .RST(RST), .channel_up(channel_up),
    .reset_Aurora(reset_Aurora), .gt_reset(gt_reset),
    .reset_TX_RX_Block(reset_TX_RX_Block), .all_up(all_up),
    .init_done(init_done), .retry_cnt(retry_cnt)
  );

  always #5 init_clk = ~init_clk;

  int checks = 0;
  int failures = 0;

  // Model state: phase 0=sequence, 1=waiting for link, 2=linked
  int          e = 0;
  int          rel = 0;
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_retry = 0;
  bit          m_ra = 1, m_gt = 1, m_all = 0, m_done = 0;
  bit [NC-1:0] m_rtx = '1;
  bit [NC-1:0] in_hist [0:MAXE];
  bit          en_hist [0:MAXE];
  bit          lit_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d rel=%0d actual=%0h required=%0h", name, e, rel, act, req);
    end
  endtask

  // One clock edge of the specification's behaviour.
  task automatic model_edge(input bit r, input bit [NC-1:0] ch);
    bit all_deb, restart, en, ok;
    int nphase, idx;
    e++;
    if (r) begin
      rel = 0; m_phase = 0; m_cnt = 0; m_retry = 0;
      m_ra = 1; m_gt = 1; m_rtx = '1; m_all = 0; m_done = 0;
      in_hist[e] = '0; en_hist[e] = 1'b0;
    end else begin
      rel++;
      all_deb = (m_rtx == '0);
      restart = 1'b0;
      nphase  = m_phase;
      if (m_phase == 0) begin
        m_ra = (m_cnt < AUR);
        if (m_cnt < GTL)                m_gt = 1;
        else if (m_cnt < GTL + GTP)     m_gt = 0;
        else if (m_cnt < GTL + 2 * GTP) m_gt = 1;
        else                            m_gt = 0;
        if (m_cnt == GTL + 2 * GTP) begin nphase = 1; m_cnt = 0; end
        else m_cnt++;
      end else if (m_phase == 1) begin
        if (all_deb) nphase = 2;
        else if (RETRY && m_cnt == LTO - 1) restart = 1'b1;
        else if (m_cnt < LTO - 1) m_cnt++;
      end else begin
        if (!all_deb) begin
          if (RETRY) restart = 1'b1;
          else begin nphase = 1; m_cnt = 0; end
        end
      end
      if (m_phase != 0) begin m_ra = 0; m_gt = 0; end
      if (restart) begin
        nphase = 0; m_cnt = 0; m_ra = 1; m_gt = 1;
        if (m_retry < 255) m_retry++;
      end
      en = (m_phase != 0) && !restart;
      en_hist[e] = en;
      in_hist[e] = ch;
      m_all = all_deb;
      // Released iff the debouncer was enabled over the last STB+1 edges and
      // the raw input was high on the STB samples that fed that count.
      for (int i = 0; i < NC; i++) begin
        ok = 1'b1;
        for (int k = 0; k <= STB; k++) begin
          idx = e - k;
          if (idx < 1 || !en_hist[idx]) ok = 1'b0;
        end
        for (int k = 2; k <= STB + 1; k++) begin
          idx = e - k;
          if (idx < 1 || !in_hist[idx][i]) ok = 1'b0;
        end
        m_rtx[i] = !ok;
      end
      m_done  = (nphase != 0);
      m_phase = nphase;
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] req);
    chk(name, act, req);
    chk({"model_", name}, mdl, req);
  endtask

  // Hand-computed timing points after a clean release of RST, channels high.
  task automatic lit_checks();
    case (rel)
      0:   lit("reset_values",
               {reset_Aurora, gt_reset, reset_TX_RX_Block, all_up, init_done, retry_cnt},
               {m_ra, m_gt, m_rtx, m_all, m_done, 8'(m_retry)}, 16'hFC00);
      100: lit("ra_hi_100",  reset_Aurora, m_ra, 1);
      101: lit("ra_lo_101",  reset_Aurora, m_ra, 0);
      490: lit("gt_hi_490",  gt_reset, m_gt, 1);
      491: lit("gt_lo_491",  gt_reset, m_gt, 0);
      500: lit("gt_lo_500",  gt_reset, m_gt, 0);
      501: lit("gt_hi_501",  gt_reset, m_gt, 1);
      510: lit("gt_hi_510",  gt_reset, m_gt, 1);
      511: lit("gt_lo_done_511", {gt_reset, init_done}, {m_gt, m_done}, 2'b01);
      519: lit("rtx_hold_519", reset_TX_RX_Block, m_rtx, 4'hF);
      520: lit("rtx_rel_520",  {reset_TX_RX_Block, all_up}, {m_rtx, m_all}, 5'b00000);
      521: lit("all_up_521",   all_up, m_all, 1);
      default: ;
    endcase
  endtask

  task automatic step(input bit r, input bit [NC-1:0] ch);
    RST = r;
    channel_up = ch;
    @(posedge init_clk);
    model_edge(r, ch);
    @(negedge init_clk);
    chk("outputs",
        {reset_Aurora, gt_reset, reset_TX_RX_Block, all_up, init_done, retry_cnt},
        {m_ra, m_gt, m_rtx, m_all, m_done, 8'(m_retry)});
    if (lit_on) lit_checks();
  endtask

  initial begin
    int zc;
    int rise [NC];
    bit [NC-1:0] ch;
    RST = 1'b1;
    channel_up = '0;
    @(negedge init_clk);

    // Power-up with all channels high from the start
    lit_on = 1'b1;
    repeat (3) step(1, 4'hF);
    repeat (540) step(0, 4'hF);
    lit_on = 1'b0;

    // Glitchy channel 0: 5 high, 1 low, repeated; must never release
    zc = 0;
    for (int s = 0; s < 36; s++) begin
      step(0, ((s % 6) == 5) ? 4'b1110 : 4'hF);
      if (s >= 7 && reset_TX_RX_Block[0] == 1'b0) zc++;
    end
    chk("glitch_hold", zc, 0);
    repeat (20) step(0, 4'hF);

    // Staggered channel rise times
    repeat (2) step(1, 4'h0);
    for (int i = 0; i < NC; i++) rise[i] = 505 + $urandom_range(0, 40);
    while (rel < 620) begin
      for (int i = 0; i < NC; i++) ch[i] = ((rel + 1) >= rise[i]);
      step(0, ch);
    end
    chk("stagger_all_up", {all_up, reset_TX_RX_Block}, 5'b10000);

    // Single-cycle drop on channel 2 while linked
    step(0, 4'b1011);
    step(0, 4'hF);
    step(0, 4'hF);
    chk("drop_rtx2", reset_TX_RX_Block[2], 1);
    repeat (30) step(0, 4'hF);

    // RST pulse mid gt_reset low pulse, then full replay
    lit_on = 1'b1;
    repeat (2) step(1, 4'hF);
    while (rel < 495) step(0, 4'hF);
    step(1, 4'hF);
    repeat (530) step(0, 4'hF);
    lit_on = 1'b0;

    // Channels stuck low (timeouts when retry is built in), then random link
    repeat (2) step(1, 4'h0);
    repeat (1200) step(0, 4'h0);
    ch = '0;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) ch[$urandom_range(0, NC - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) ch = 4'hF;
      step(0, ch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
